// File: rtl/pipeline_control.sv
// pipeline_control
//   Central stall/flush sequencer for the five-stage pipeline. Arbitrates the
//   hazard and resource requests from ID, EX and MEM, drives per-latch hold
//   (stall) and bubble (flush) enables, runs the multi-cycle divide sequencer
//   and raises the exception redirect.
//
// Ports
//   clock               rising-edge clock
//   reset               asynchronous, active-low; 0 clears state and forces
//                       every output to 0
//   id_stall_request    load-use hazard detected in ID
//   ex_divide_start     EX holds div/divu (level, held while it sits in EX)
//   mem_stall_request   data memory not ready
//   mem_exception       instruction in MEM raised an exception
//   stall[4:0]          hold enables: [0] PC, [1] if_id, [2] id_ex,
//                       [3] ex_mem, [4] mem_wb
//   flush[4:0]          bubble enables, same indexing; [0] is always 0
//   divide_ready        one-cycle pulse, divider result valid this cycle
//   pc_redirect_enable  load pc_redirect_address into PC
//   pc_redirect_address EXCEPTION_VECTOR when redirecting, else 0
//   debug_state         current sequencer state (0 = RUN, 1 = DIVIDE)
//
// Request interface: every request is a plain level sampled in the same cycle
// it is raised; the controls it produces are valid in that cycle. There is no
// handshake - a requester keeps its request high for as long as it needs it.
module pipeline_control #(
    parameter int          DIVIDE_CYCLES    = 32,
    parameter logic [31:0] EXCEPTION_VECTOR = 32'h0000_0020,
    localparam int         COUNT_W          = $clog2(DIVIDE_CYCLES)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        id_stall_request,
    input  logic        ex_divide_start,
    input  logic        mem_stall_request,
    input  logic        mem_exception,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        divide_ready,
    output logic        pc_redirect_enable,
    output logic [31:0] pc_redirect_address,
    output logic        debug_state
);

    typedef enum logic {
        RUN    = 1'b0,
        DIVIDE = 1'b1
    } state_t;

    state_t               state;
    logic   [COUNT_W-1:0] count;
    logic                 divide_active;

    // The divide stall covers the start cycle in RUN plus every DIVIDE cycle
    // with a nonzero count; the count==0 cycle is the result cycle.
    assign divide_active = (state == RUN    && ex_divide_start) ||
                           (state == DIVIDE && count != '0);

    assign debug_state = (state == DIVIDE);

    always_comb begin
        stall               = 5'b00000;
        flush               = 5'b00000;
        divide_ready        = 1'b0;
        pc_redirect_enable  = 1'b0;
        pc_redirect_address = 32'h0000_0000;
        if (!reset) begin
            // Outputs held at 0 while in reset, regardless of requests.
        end else if (mem_exception) begin
            flush               = 5'b11110;
            pc_redirect_enable  = 1'b1;
            pc_redirect_address = EXCEPTION_VECTOR;
        end else if (mem_stall_request) begin
            stall = 5'b01111;
            flush = 5'b10000;
        end else if (divide_active) begin
            stall = 5'b00111;
            flush = 5'b01000;
        end else begin
            // Result cycle of a divide; a load-use stall may coexist with it.
            divide_ready = (state == DIVIDE);
            if (id_stall_request) begin
                stall = 5'b00011;
                flush = 5'b00100;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
            count <= '0;
        end else if (mem_exception) begin
            // Abort any divide in flight; the result is never delivered.
            state <= RUN;
            count <= '0;
        end else if (mem_stall_request) begin
            // Frozen: each MEM stall cycle lengthens a divide by one cycle.
            state <= state;
            count <= count;
        end else begin
            case (state)
                RUN: begin
                    if (ex_divide_start) begin
                        state <= DIVIDE;
                        count <= COUNT_W'(DIVIDE_CYCLES - 1);
                    end
                end
                DIVIDE: begin
                    // ex_divide_start is ignored here so the held
                    // instruction cannot retrigger the sequencer.
                    if (count != '0) begin
                        count <= count - COUNT_W'(1);
                    end else begin
                        state <= RUN;
                    end
                end
                default: begin
                    state <= RUN;
                    count <= '0;
                end
            endcase
        end
    end

endmodule
